chan_scan_mux: RTL and testbench

- Parametrised successor to the team's 4:1 pin selector: N-channel, W-bit-wide registered multiplexer.
- Two modes: manual (select latched on strobe) and auto-scan (channel advances every programmable dwell period).
- Sits between the user input pins and the dedicated output pins of the tile.
- Provides the current-channel index and a scan-wrap pulse for downstream logging and LEDs.

---
 rtl/chan_scan_mux.sv | 128 ++++++++++++
 tb/tb_chan_scan_mux.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: N-channel, W-bit registered multiplexer with two modes.
// In manual mode a strobed select is latched. In auto-scan mode the channel
// advances after each dwell period, and a wrap pulse marks the return to the
// start of the scan.
// Optional macro CHAN_SCAN_MUX_SKIP_MASK_EN adds a skip_mask port. Channels
// whose mask bit is set are passed over by auto-scan.
module chan_scan_mux #(
    parameter  int NCH     = 4,
    parameter  int W       = 1,
    parameter  int DWELL_W = 8,
    localparam int SELW    = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [NCH*W-1:0]     din,
    input  logic [SELW-1:0]      sel,
    input  logic                 load,
    input  logic                 mode,
    input  logic [DWELL_W-1:0]   dwell,
`ifdef CHAN_SCAN_MUX_SKIP_MASK_EN
    input  logic [NCH-1:0]       skip_mask,
`endif
    output logic [W-1:0]         dout,
    output logic [SELW-1:0]      cur_ch,
    output logic                 wrap
);

    localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

    logic [SELW-1:0]    ch_q, ch_d, nxt_ch;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]       dout_q, dout_d, dsel;
    logic               wrap_q, wrap_d;
    logic               adv_ok, wrap_nx, sel_ok;

    // A select index is only usable when it names an existing channel.
    // With a power-of-two channel count every encoding is valid.
    generate
        if (NCH == (1 << SELW)) begin : g_sel_full
            assign sel_ok = 1'b1;
        end else begin : g_sel_range
            assign sel_ok = (sel <= LAST);
        end
    endgenerate

`ifdef CHAN_SCAN_MUX_SKIP_MASK_EN
    // Search cyclically for the nearest unmasked channel after ch.
    // The wrap-around is done by compare, so non-power-of-two NCH works.
    always_comb begin
        logic [SELW:0] sum;
        adv_ok = 1'b0;
        nxt_ch = ch_q;
        sum    = '0;
        for (int i = 1; i < NCH; i++) begin
            sum = {1'b0, ch_q} + (SELW+1)'(i);
            if (sum >= (SELW+1)'(NCH)) sum = sum - (SELW+1)'(NCH);
            if (!adv_ok && !skip_mask[sum[SELW-1:0]]) begin
                adv_ok = 1'b1;
                nxt_ch = sum[SELW-1:0];
            end
        end
        wrap_nx = adv_ok && (nxt_ch <= ch_q);
    end
`else
    // Plain cyclic successor; the last channel rolls back to 0.
    always_comb begin
        adv_ok  = 1'b1;
        wrap_nx = (ch_q == LAST);
        nxt_ch  = (ch_q == LAST) ? '0 : ch_q + 1'b1;
    end
`endif

    // Channel data mux, indexed by the current channel register.
    always_comb begin
        dsel = '0;
        for (int k = 0; k < NCH; k++)
            if (ch_q == SELW'(k)) dsel = din[k*W +: W];
    end

    // Next state. The priority is a valid load, then an auto advance, then
    // hold. When ena is low, everything holds except wrap, which drops to 0.
    always_comb begin
        ch_d   = ch_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        dout_d = dout_q;
        if (ena) begin
            dout_d = dsel;
            if (load && sel_ok) begin
                ch_d  = sel;
                cnt_d = '0;
            end else if (mode) begin
                if (cnt_q == dwell) begin
                    cnt_d = '0;
                    if (adv_ok) begin
                        ch_d   = nxt_ch;
                        wrap_d = wrap_nx;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            ch_q   <= ch_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            wrap_q <= wrap_d;
        end
    end

    assign dout   = dout_q;
    assign cur_ch = ch_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux. It drives two instances: NCH=4/W=1 and NCH=3/W=2.
// A behavioural model of each instance is compared against the DUT outputs
// on every cycle. Literal checks pin the directed scenarios.
module tb_chan_scan_mux;

    logic clk = 1'b0;
    logic rst_n, ena;

    logic [3:0] din4;  logic [1:0] sel4; logic load4, mode4; logic [7:0] dwell4; logic [3:0] mask4;
    logic [1:0] dout4; logic [1:0] cur4; logic wrap4;
    logic [5:0] din3;  logic [1:0] sel3; logic load3, mode3; logic [7:0] dwell3; logic [2:0] mask3;
    logic [1:0] dout3; logic [1:0] cur3; logic wrap3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    chan_scan_mux #(.NCH(4), .W(1), .DWELL_W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din4), .sel(sel4), .load(load4),
        .mode(mode4), .dwell(dwell4),
`ifdef CHAN_SCAN_MUX_SKIP_MASK_EN
        .skip_mask(mask4),
`endif
        .dout(dout4[0]), .cur_ch(cur4), .wrap(wrap4));
    assign dout4[1] = 1'b0;

    chan_scan_mux #(.NCH(3), .W(2), .DWELL_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din3), .sel(sel3), .load(load3),
        .mode(mode3), .dwell(dwell3),
`ifdef CHAN_SCAN_MUX_SKIP_MASK_EN
        .skip_mask(mask3),
`endif
        .dout(dout3), .cur_ch(cur3), .wrap(wrap3));

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One model step, straight from the behavioural rules.
    function automatic void mstep(input int nch, input int ch, input int cnt,
                                  input bit ld, input int sl, input bit md,
                                  input int dw, input int mask,
                                  output int ch_o, output int cnt_o, output bit wr_o);
        ch_o = ch; cnt_o = cnt; wr_o = 1'b0;
        if (ld && sl < nch) begin
            ch_o = sl; cnt_o = 0;
        end else if (!md) begin
            cnt_o = 0;
        end else if (cnt != dw) begin
            cnt_o = (cnt + 1) % 256;
        end else begin
            cnt_o = 0;
            for (int i = 1; i < nch; i++) begin
                int c;
                c = (ch + i) % nch;
                if (!mask[c]) begin
                    ch_o = c; wr_o = (c <= ch);
                    break;
                end
            end
        end
    endfunction

    int m4_ch, m4_cnt, m4_dout; bit m4_wrap;
    int m3_ch, m3_cnt, m3_dout; bit m3_wrap;

    // Reference model updates on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        int c4, n4, c3, n3; bit w4, w3;
        if (!rst_n) begin
            m4_ch = 0; m4_cnt = 0; m4_dout = 0; m4_wrap = 0;
            m3_ch = 0; m3_cnt = 0; m3_dout = 0; m3_wrap = 0;
        end else if (ena) begin
            m4_dout = int'(din4[m4_ch]);
            m3_dout = int'(din3[m3_ch*2 +: 2]);
            mstep(4, m4_ch, m4_cnt, load4, int'(sel4), mode4, int'(dwell4), int'(mask4), c4, n4, w4);
            mstep(3, m3_ch, m3_cnt, load3, int'(sel3), mode3, int'(dwell3), int'(mask3), c3, n3, w3);
            m4_ch = c4; m4_cnt = n4; m4_wrap = w4;
            m3_ch = c3; m3_cnt = n3; m3_wrap = w3;
        end else begin
            m4_wrap = 0; m3_wrap = 0;
        end
    end

    // Every-cycle compare of both DUTs against the model.
    always @(negedge clk) begin
        chk("u4_cur_ch", int'(cur4),  m4_ch);
        chk("u4_dout",   int'(dout4), m4_dout);
        chk("u4_wrap",   int'(wrap4), int'(m4_wrap));
        chk("u3_cur_ch", int'(cur3),  m3_ch);
        chk("u3_dout",   int'(dout3), m3_dout);
        chk("u3_wrap",   int'(wrap3), int'(m3_wrap));
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    int exp_scan[13] = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
    int exp_d0[7]    = '{0,1,2,0,1,2,0};
    int exp_d0w[7]   = '{0,0,0,1,0,0,1};

    initial begin
        int c;
        rst_n = 1'b0; ena = 1'b1;
        din4 = 4'b1111; sel4 = '0; load4 = 0; mode4 = 0; dwell4 = '0; mask4 = '0;
        din3 = 6'b100100; sel3 = '0; load3 = 0; mode3 = 0; dwell3 = '0; mask3 = '0;
        repeat (3) tick;
        chk("rst_dout", int'(dout4), 0);
        chk("rst_cur_ch", int'(cur4), 0);
        rst_n = 1'b1;
        tick;
        chk("first_edge_dout", int'(dout4), 1);

        // Manual select
        din4 = 4'b0100; load4 = 1; sel4 = 2'd2;
        tick; load4 = 0;
        chk("man_cur_ch", int'(cur4), 2);
        chk("man_dout_pre", int'(dout4), 0);
        tick;
        chk("man_dout", int'(dout4), 1);

        // Out-of-range select is ignored (NCH=3, sel=3)
        load3 = 1; sel3 = 2'd1;
        tick; sel3 = 2'd3;
        tick; load3 = 0;
        chk("bad_sel_hold", int'(cur3), 1);

        // Auto scan, dwell=2
        load4 = 1; sel4 = 2'd0; mode4 = 1; dwell4 = 8'd2;
        tick; load4 = 0;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) tick;
            chk("scan_ch", int'(cur4), exp_scan[k]);
            chk("scan_wrap", int'(wrap4), (k == 12) ? 1 : 0);
        end

        // Load wins over an advance due on the same edge
        load4 = 1; sel4 = 2'd0;
        tick; load4 = 0;
        tick; tick;
        load4 = 1; sel4 = 2'd1;
        tick; load4 = 0;
        chk("prio_ch", int'(cur4), 1);
        chk("prio_wrap", int'(wrap4), 0);
        tick; chk("prio_cnt1", int'(cur4), 1);
        tick; chk("prio_cnt2", int'(cur4), 1);
        tick; chk("prio_adv", int'(cur4), 2);

        // ena low freezes state
        c = int'(cur4);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("ena_freeze_ch", int'(cur4), c);
            chk("ena_freeze_wrap", int'(wrap4), 0);
        end
        ena = 1'b1;

        // dwell=0 on NCH=3
        load3 = 1; sel3 = 2'd0; mode3 = 1; dwell3 = 8'd0;
        tick; load3 = 0;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick;
            chk("d0_ch", int'(cur3), exp_d0[k]);
            chk("d0_wrap", int'(wrap3), exp_d0w[k]);
        end

`ifdef CHAN_SCAN_MUX_SKIP_MASK_EN
        mask4 = 4'b0110; load4 = 1; sel4 = 2'd0; mode4 = 1; dwell4 = 8'd0;
        tick; load4 = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick;
            chk("mask_ch", int'(cur4), (k % 2 == 0) ? 0 : 3);
            chk("mask_wrap", int'(wrap4), (k == 2) ? 1 : 0);
        end
        mask4 = 4'b1110; load4 = 1; sel4 = 2'd0;
        tick; load4 = 0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("mask_all_ch", int'(cur4), 0);
            chk("mask_all_wrap", int'(wrap4), 0);
        end
        mask4 = '0;
`endif

        // Randomized phase
        for (int k = 0; k < 3000; k++) begin
            tick;
            rst_n  = ($urandom_range(0, 199) != 0);
            ena    = ($urandom_range(0, 7) != 0);
            din4   = 4'($urandom);
            din3   = 6'($urandom);
            sel4   = 2'($urandom);
            sel3   = 2'($urandom);
            load4  = ($urandom_range(0, 5) == 0);
            load3  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) mode4 = ~mode4;
            if ($urandom_range(0, 15) == 0) mode3 = ~mode3;
            if ($urandom_range(0, 31) == 0) dwell4 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) dwell3 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
`ifdef CHAN_SCAN_MUX_SKIP_MASK_EN
            if ($urandom_range(0, 63) == 0) mask4 = 4'($urandom);
            if ($urandom_range(0, 63) == 0) mask3 = 3'($urandom);
`endif
        end
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
